// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive and transmit paths.
//   - parity encoding constants (PAR_NONE / PAR_ODD / PAR_EVEN)
//   - default clocks-per-bit for 115200 baud on a 50 MHz clock
//   - receiver FSM state encoding
//   - 3-input majority helper used by the bit voter
package uart_pkg;

    localparam int BAUD_DIV_DEFAULT = 434;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO with registered head data.
//   clk   : clock
//   rst   : synchronous active-high reset (empties the FIFO, clears head)
//   push  : write din; accepted when not full, or when a pop happens too
//   din   : write data
//   pop   : remove head entry; ignored while empty
//   dout  : registered head-of-FIFO data
//   full  : FIFO holds DEPTH entries
//   empty : FIFO holds no entries
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [AW:0]      rd_ptr_next;
    logic [WIDTH-1:0] head_reg;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    assign do_pop      = pop & ~empty;
    assign do_push     = push & (~full | do_pop);
    assign rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, do_pop};

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    // The head register tracks the entry at rd_ptr_next. When that slot is the
    // one being written this cycle the array still holds stale data, so the
    // incoming word is forwarded directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            head_reg   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            rd_ptr_reg <= rd_ptr_next;
            if (do_push && (wr_ptr_reg == rd_ptr_next)) begin
                head_reg <= din;
            end else if (do_pop) begin
                head_reg <= mem[rd_ptr_next[AW-1:0]];
            end
        end
    end

    assign dout = head_reg;

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with majority-vote sampling and RX FIFO.
//   clk        : system clock
//   rst        : synchronous active-high reset
//   rx         : asynchronous serial input, idles high
//   data_out   : head-of-FIFO data word
//   frame_err  : head entry had a low stop bit
//   parity_err : head entry failed the parity check
//   break_det  : head entry was a break (all bits low)
//   valid      : FIFO not empty
//   ready      : consumer pops the head when valid && ready
//   overrun    : one-cycle pulse after a completed frame was dropped (FIFO full)
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = BAUD_DIV_DEFAULT,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = PAR_NONE,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 break_det,
    output logic                 valid,
    input  logic                 ready,
    output logic                 overrun
);

    localparam int MID     = BAUD_DIV / 2;
    localparam int CNT_W   = $clog2(BAUD_DIV);
    localparam int BIT_W   = $clog2(DATA_BITS);
    localparam int ENTRY_W = DATA_BITS + 3;

    localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(MID);
    localparam logic [CNT_W-1:0] CNT_VOTE = CNT_W'(MID + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rxs;
    logic                   rxs_prev_reg;

    rx_state_t              state_reg;
    rx_state_t              state_next;

    logic [CNT_W-1:0]       cnt_reg;
    logic                   samp0_reg;
    logic                   samp1_reg;
    logic [DATA_BITS-1:0]   shift_reg;
    logic [BIT_W-1:0]       bit_idx_reg;
    logic                   stop_idx_reg;
    logic                   par_bit_reg;
    logic                   frame_err_reg;
    logic                   overrun_reg;

    logic                   vote;
    logic                   at_vote;
    logic                   at_end;
    logic                   fall_edge;
    logic                   last_data;
    logic                   last_stop;

    logic                   push;
    logic                   frame_err_new;
    logic                   parity_err_new;
    logic                   break_new;
    logic                   data_par;
    logic [ENTRY_W-1:0]     entry;

    logic [ENTRY_W-1:0]     head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop_fire;

    // Input synchroniser, idles high so reset does not look like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg     <= '1;
            rxs_prev_reg <= 1'b1;
        end else begin
            sync_reg     <= {sync_reg[SYNC_STAGES-2:0], rx};
            rxs_prev_reg <= rxs;
        end
    end

    assign rxs       = sync_reg[SYNC_STAGES-1];
    assign fall_edge = rxs_prev_reg & ~rxs;

    // The two early samples are held; the third is the live input, so the
    // vote is valid exactly when cnt reaches the third sample point.
    assign vote      = majority3(samp0_reg, samp1_reg, rxs);
    assign at_vote   = (cnt_reg == CNT_VOTE);
    assign at_end    = (cnt_reg == CNT_LAST);
    assign last_data = (bit_idx_reg == BIT_W'(DATA_BITS - 1));
    assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_idx_reg;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (fall_edge) state_next = ST_START;
            end
            ST_START: begin
                if (at_vote && vote) state_next = ST_IDLE;
                else if (at_end)     state_next = ST_DATA;
            end
            ST_DATA: begin
                if (at_end && last_data) begin
                    state_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (at_end) state_next = ST_STOP;
            end
            ST_STOP: begin
                // Leaving at the last vote (mid-bit) lets a back-to-back start
                // edge be caught without a gap.
                if (at_vote && last_stop) begin
                    state_next = rxs ? ST_IDLE : ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (rxs) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        push           = 1'b0;
        frame_err_new  = frame_err_reg | ~vote;
        data_par       = (^shift_reg) ^ par_bit_reg;
        parity_err_new = 1'b0;
        break_new      = 1'b0;
        if (PARITY == PAR_ODD) begin
            parity_err_new = ~data_par;
        end else if (PARITY == PAR_EVEN) begin
            parity_err_new = data_par;
        end
        break_new = (shift_reg == '0) &&
                    ((PARITY == PAR_NONE) || !par_bit_reg) &&
                    frame_err_new;
        if ((state_reg == ST_STOP) && at_vote && last_stop) begin
            push = 1'b1;
        end
    end

    assign entry = {break_new, parity_err_new, frame_err_new, shift_reg};

    // ---------------- Bit timing and data path ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg       <= '0;
            samp0_reg     <= 1'b1;
            samp1_reg     <= 1'b1;
            shift_reg     <= '0;
            bit_idx_reg   <= '0;
            stop_idx_reg  <= 1'b0;
            par_bit_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            if (cnt_reg == CNT_S0) samp0_reg <= rxs;
            if (cnt_reg == CNT_S1) samp1_reg <= rxs;

            // cnt idles at 0 so the START bit begins counting from a clean zero.
            if (state_reg == ST_IDLE || state_reg == ST_WAIT_IDLE || at_end) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end

            case (state_reg)
                ST_START: begin
                    bit_idx_reg   <= '0;
                    stop_idx_reg  <= 1'b0;
                    frame_err_reg <= 1'b0;
                    par_bit_reg   <= 1'b0;
                end
                ST_DATA: begin
                    // LSB arrives first: shift right, new bit enters at the top.
                    if (at_vote) shift_reg <= {vote, shift_reg[DATA_BITS-1:1]};
                    if (at_end)  bit_idx_reg <= bit_idx_reg + 1'b1;
                end
                ST_PARITY: begin
                    if (at_vote) par_bit_reg <= vote;
                end
                ST_STOP: begin
                    if (at_vote) frame_err_reg <= frame_err_new;
                    if (at_end)  stop_idx_reg <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    assign pop_fire = ready & ~fifo_empty;

    uart_rx_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (entry),
        .pop   (ready),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_reg <= 1'b0;
        end else begin
            overrun_reg <= push & fifo_full & ~pop_fire;
        end
    end

    assign data_out   = head[DATA_BITS-1:0];
    assign frame_err  = head[DATA_BITS];
    assign parity_err = head[DATA_BITS+1];
    assign break_det  = head[DATA_BITS+2];
    assign valid      = ~fifo_empty;
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed bench for uart_rx_param.
//   dut_a : 8N1, FIFO depth 4
//   dut_b : 8 data bits, even parity, 2 stop bits
// Both use 16 clocks per bit to keep frames short.
module tb_uart_rx_param;

    localparam int BD = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       rx_a = 1'b1;
    logic       ready_a = 1'b0;
    logic [7:0] data_out_a;
    logic       frame_err_a, parity_err_a, break_det_a, valid_a, overrun_a;

    logic       rx_b = 1'b1;
    logic       ready_b = 1'b0;
    logic [7:0] data_out_b;
    logic       frame_err_b, parity_err_b, break_det_b, valid_b, overrun_b;

    int tests = 0;
    int fails = 0;
    int ovr_cycles_a = 0;

    // Popped entries, packed as {break_det, parity_err, frame_err, data}.
    logic [10:0] qa[$];
    logic [10:0] qb[$];

    always #5 clk = ~clk;

    uart_rx_param #(
        .BAUD_DIV(BD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_a (
        .clk(clk), .rst(rst), .rx(rx_a), .data_out(data_out_a),
        .frame_err(frame_err_a), .parity_err(parity_err_a), .break_det(break_det_a),
        .valid(valid_a), .ready(ready_a), .overrun(overrun_a)
    );

    uart_rx_param #(
        .BAUD_DIV(BD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
    ) dut_b (
        .clk(clk), .rst(rst), .rx(rx_b), .data_out(data_out_b),
        .frame_err(frame_err_b), .parity_err(parity_err_b), .break_det(break_det_b),
        .valid(valid_b), .ready(ready_b), .overrun(overrun_b)
    );

    always @(negedge clk) begin
        if (valid_a && ready_a) begin
            qa.push_back({break_det_a, parity_err_a, frame_err_a, data_out_a});
            $display("[TB] pop A data=%02h fe=%0b pe=%0b brk=%0b",
                     data_out_a, frame_err_a, parity_err_a, break_det_a);
        end
        if (valid_b && ready_b) begin
            qb.push_back({break_det_b, parity_err_b, frame_err_b, data_out_b});
            $display("[TB] pop B data=%02h fe=%0b pe=%0b brk=%0b",
                     data_out_b, frame_err_b, parity_err_b, break_det_b);
        end
        if (overrun_a) ovr_cycles_a++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives bits[0..n-1] onto line 0 (rx_a) or 1 (rx_b), one bit time each.
    task automatic send_bits(input int line, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (line == 0) rx_a = bits[i];
            else           rx_b = bits[i];
            tick(BD);
        end
    endtask

    task automatic send_a(input logic [7:0] d, input logic stop);
        send_bits(0, {6'h3f, stop, d, 1'b0}, 10);
        $display("[TB] sent A data=%02h stop=%0b", d, stop);
    endtask

    task automatic send_b(input logic [7:0] d, input logic par);
        send_bits(1, {4'hf, 1'b1, 1'b1, par, d, 1'b0}, 12);
        $display("[TB] sent B data=%02h par=%0b", d, par);
    endtask

    initial begin
        // Reset state
        tick(5);
        check("rst_valid_a", valid_a, 0);
        check("rst_overrun_a", overrun_a, 0);
        check("rst_data_a", data_out_a, 0);
        check("rst_flags_a", {break_det_a, parity_err_a, frame_err_a}, 0);
        rst = 1'b0;
        tick(3);
        check("post_rst_valid_b", valid_b, 0);

        // 8N1 back-to-back 0x41, 0x35
        ready_a = 1'b1;
        send_a(8'h41, 1'b1);
        send_a(8'h35, 1'b1);
        tick(3 * BD);
        check("n81_count", qa.size(), 2);
        check("n81_first", qa[0], 11'h041);
        check("n81_second", qa[1], 11'h035);

        // Even parity: correct then wrong parity bit
        ready_b = 1'b1;
        send_b(8'h35, 1'b0);
        send_b(8'h35, 1'b1);
        tick(3 * BD);
        check("par_count", qb.size(), 2);
        check("par_ok", qb[0], 11'h035);
        check("par_bad", qb[1], 11'h235);

        // Short glitch must not produce an entry; a real frame afterwards must
        qa.delete();
        rx_a = 1'b0;
        tick(4);
        rx_a = 1'b1;
        tick(4 * BD);
        check("glitch_count", qa.size(), 0);
        check("glitch_valid", valid_a, 0);
        send_a(8'h35, 1'b1);
        tick(3 * BD);
        check("post_glitch_count", qa.size(), 1);
        check("post_glitch_data", qa[0], 11'h035);

        // Framing error, then a break held for 20 bit times
        qa.delete();
        send_a(8'hA5, 1'b0);
        rx_a = 1'b1;
        tick(BD);
        rx_a = 1'b0;
        tick(20 * BD);
        check("break_count_low", qa.size(), 2);
        rx_a = 1'b1;
        tick(4 * BD);
        check("break_count_high", qa.size(), 2);
        check("frame_err_entry", qa[0], 11'h1A5);
        check("break_entry", qa[1], 11'h500);

        // Overrun: fill a depth-4 FIFO with five frames
        qa.delete();
        ready_a = 1'b0;
        ovr_cycles_a = 0;
        for (int d = 1; d <= 5; d++) send_a(8'(d), 1'b1);
        tick(3 * BD);
        check("ovr_cycles", ovr_cycles_a, 1);
        check("ovr_valid", valid_a, 1);
        check("ovr_head", data_out_a, 8'h01);
        ready_a = 1'b1;
        tick(10);
        ready_a = 1'b0;
        check("drain_count", qa.size(), 4);
        for (int k = 0; k < 4; k++) check($sformatf("drain_%0d", k), qa[k], 32'(k + 1));
        check("drain_valid", valid_a, 0);

        // Reset during data bit 3 empties the FIFO and drops the partial frame
        qa.delete();
        send_a(8'h35, 1'b1);
        tick(3 * BD);
        check("pre_rst_valid", valid_a, 1);
        send_bits(0, {6'h3f, 1'b1, 8'h41, 1'b0}, 4);
        rx_a = 1'b0;
        tick(BD / 2);
        rst = 1'b1;
        rx_a = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(4 * BD);
        check("mid_rst_valid", valid_a, 0);
        check("mid_rst_overrun", overrun_a, 0);
        ready_a = 1'b1;
        send_a(8'h41, 1'b1);
        tick(3 * BD);
        check("post_rst_count", qa.size(), 1);
        check("post_rst_data", qa[0], 11'h041);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver, the next generation of the fixed 8N1 receiver. It adds configurable data width, optional parity, and one or two stop bits. Each bit is sampled by a 3-sample majority vote, and frame, parity, break and overrun conditions are reported. Received words go into a small RX FIFO drained by a valid/ready handshake. The block sits between the `rx` pin and the system bus/consumer logic, on the 50 MHz system clock.

## Interface
One clock; reset is synchronous and active-high.

Parameters:
- `BAUD_DIV`, 434: clocks per bit (50 MHz / 115200); legal range ≥ 16.
- `DATA_BITS`, 8: data bits per frame, 5..9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: RX FIFO entries, power of two, ≥ 2.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: synchronous active-high reset.
- `rx`, in, 1: asynchronous serial input; idles high.
- `data_out`, out, `DATA_BITS`: head-of-FIFO data word.
- `frame_err`, out, 1: head entry had a low stop bit.
- `parity_err`, out, 1: head entry failed the parity check (0 when `PARITY`=0).
- `break_det`, out, 1: head entry was a break (all bits low, including parity and stop).
- `valid`, out, 1: FIFO not empty.
- `ready`, in, 1: consumer pops the head when `valid && ready`.
- `overrun`, out, 1: one-cycle pulse when a completed frame is dropped because the FIFO is full.

## Operation
- `rx` passes through a 2-FF synchroniser whose flops reset to 1. All logic below uses the synchronised signal `rxs`.
- Bit counter `cnt` runs 0..`BAUD_DIV`-1. Sample points are `M-1`, `M` and `M+1`, where `M = BAUD_DIV/2` (integer division). The bit value is the majority of the three samples, resolved at `cnt == M+1`.
- FSM states: `IDLE`, `START`, `DATA`, `PARITY`, `STOP`, `WAIT_IDLE`.
  - `IDLE`: on an `rxs` falling edge, clear `cnt` and go to `START`.
  - `START`: if the voted bit is 1, treat it as a glitch and return to `IDLE` with no output. If it is 0, continue counting to the end of the bit, then go to `DATA`.
  - `DATA`: shift the voted bit in LSB first. After `DATA_BITS` bits, go to `PARITY` if `PARITY` ≠ 0, otherwise go to `STOP`.
  - `PARITY`: compute `parity_err` as odd/even XOR over data plus the parity bit.
  - `STOP`: sample `STOP_BITS` stop bits. Any low stop bit sets `frame_err`. At the last stop sample, push `{break_det, parity_err, frame_err, data}` into the FIFO. Then go to `IDLE` if `rxs` = 1, else go to `WAIT_IDLE`.
  - `WAIT_IDLE`: stay until `rxs` = 1, then go to `IDLE`. A break therefore produces exactly one entry.
- `break_det` requires all data bits = 0, parity bit (if present) = 0, and `frame_err` = 1.
- FIFO behaviour:
  - A push is accepted when the FIFO is not full, or when a pop happens in the same cycle.
  - Otherwise the frame is dropped, `overrun` pulses, and the FIFO contents stay unchanged.
  - Simultaneous push and pop on an empty FIFO: the push is written and the pop is ignored, because `valid` was 0.
  - Pointers are `log2(FIFO_DEPTH)`+1 bits and wrap naturally.
- Reset mid-frame: the FSM returns to `IDLE`, the partial frame is discarded, and the FIFO is emptied.

## Timing
- Reset values:
  - `valid`=0, `overrun`=0.
  - `data_out`=0, `frame_err`=0, `parity_err`=0, `break_det`=0.
  - Synchroniser flops=1, FSM=`IDLE`.
- Pin-to-FSM delay is 2 cycles (synchroniser) plus 1 cycle for edge detection.
- The FIFO write happens on the clock edge of the last stop-bit vote (`cnt == M+1`). `valid` rises on the next cycle.
- Head outputs are registered FIFO read data. They change in the cycle after a pop and stay stable while `valid && !ready`.
- `overrun` is high for exactly the one cycle after the dropped push.
- Back-to-back frames are received with no gap, because the next start edge is searched for from the middle of the stop bit.

## Structure
- Shared package `uart_pkg` holds:
  - the parity encoding constants (`PAR_NONE`, `PAR_ODD`, `PAR_EVEN`);
  - the FSM state encoding;
  - the default `BAUD_DIV` constant of 434.
- Sub-module `uart_rx_fifo`: a synchronous FIFO with parameters `WIDTH` and `DEPTH`. It provides push, pop, full, empty and registered head data, and is reused later by the TX path.

## Test plan
- 8N1, send 0x41 then 0x35 with `ready`=1 → two pops, `data_out` = 0x41 then 0x35, all error flags 0.
- `PARITY`=2 (even), send 0x35 with parity bit 0, then the same frame with parity bit 1 → first entry has `parity_err`=0, second has `parity_err`=1, data 0x35 in both.
- `rx` pulled low for 100 cycles then high (glitch) → no FIFO entry, FSM back in `IDLE`.
- Send 0xA5 with the stop bit held low, then hold `rx` low for 20 bit times → one entry with `frame_err`=1 and `break_det`=0. Then one break entry with data 0, `frame_err`=1, `break_det`=1, and no further entries until `rx` returns high.
- `FIFO_DEPTH`=4, `ready`=0, send 0x01..0x05 → `overrun` pulses once after frame 5. Draining yields 0x01..0x04.
- Assert `rst` during data bit 3 of a frame → `valid` stays 0, and the next clean 0x41 frame is received correctly.
